// File: rtl/ov7670_pixel_capture.sv
// rtl/ov7670_pixel_capture.sv - OV7670 parallel bus oversampler and RGB444 pixel assembler
module ov7670_pixel_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_done,
  input  logic        cmos_pclk,
  input  logic        cmos_href,
  input  logic        cmos_vsync,
  input  logic [7:0]  cmos_data,
  input  logic        pix_full,
  output logic        pix_wr_en,
  output logic [11:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_start,
  output logic        frame_done,
  output logic        overflow,
  output logic        line_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {WAIT_CFG, WAIT_VS, BYTE1, BYTE2} state_t;

  localparam logic [9:0] H_MAX = 10'(H_PIXELS);
  localparam logic [8:0] V_MAX = 9'(V_LINES);

  state_t      state, state_nxt;
  logic        pclk_s1, pclk_s2, pclk_s3;
  logic        href_s1, href_s2;
  logic        vsync_s1, vsync_s2, vsync_s3;
  logic [7:0]  data_s1, data_s2;
  logic [3:0]  r_nib;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        line_seen;

  logic        pclk_rise, vs_rise, vs_fall;
  logic        frame_begin, frame_end, take_byte1, take_byte2, line_end;
  logic        in_range, wr_go, ovf_set, lerr_set, fd_go;

  assign pclk_rise = pclk_s2 & ~pclk_s3;
  assign vs_rise   = vsync_s2 & ~vsync_s3;
  assign vs_fall   = ~vsync_s2 & vsync_s3;

  // Bring the asynchronous camera bus into the clk domain; data and href share pclk's latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {pclk_s1, pclk_s2, pclk_s3}    <= '0;
      {href_s1, href_s2}             <= '0;
      {vsync_s1, vsync_s2, vsync_s3} <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      {pclk_s1, pclk_s2, pclk_s3}    <= {cmos_pclk, pclk_s1, pclk_s2};
      {href_s1, href_s2}             <= {cmos_href, href_s1};
      {vsync_s1, vsync_s2, vsync_s3} <= {cmos_vsync, vsync_s1, vsync_s2};
      data_s1 <= cmos_data;
      data_s2 <= data_s1;
    end
  end

  // Capture state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_CFG;
    else        state <= state_nxt;
  end

  // Next-state selection; losing cfg_done always returns to WAIT_CFG
  always_comb begin
    state_nxt = state;
    if (!cfg_done) begin
      state_nxt = WAIT_CFG;
    end else begin
      case (state)
        WAIT_CFG: state_nxt = WAIT_VS;
        WAIT_VS:  if (frame_begin) state_nxt = BYTE1;
        BYTE1, BYTE2: begin
          if (frame_end)                    state_nxt = WAIT_VS;
          else if (take_byte1)              state_nxt = BYTE2;
          else if (take_byte2 || line_end)  state_nxt = BYTE1;
        end
        default: state_nxt = WAIT_CFG;
      endcase
    end
  end

  // Per-cycle action decode: which byte/line/frame event happens and what it implies
  always_comb begin
    frame_begin = 1'b0;
    frame_end   = 1'b0;
    take_byte1  = 1'b0;
    take_byte2  = 1'b0;
    line_end    = 1'b0;
    if (cfg_done) begin
      case (state)
        WAIT_VS: frame_begin = vs_fall;
        BYTE1, BYTE2: begin
          if (vs_rise) begin
            frame_end = 1'b1;
          end else if (pclk_rise) begin
            if (href_s2) begin
              take_byte1 = (state == BYTE1);
              take_byte2 = (state == BYTE2);
            end else if (line_seen) begin
              line_end = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    in_range = (x < H_MAX) && (y < V_MAX);
    wr_go    = take_byte2 & in_range & ~pix_full;
    ovf_set  = take_byte2 & in_range & pix_full;
    lerr_set = (take_byte2 & ~in_range)
             | (line_end & ((state == BYTE2) | (x != H_MAX)))
             | (frame_end & (y != V_MAX));
    fd_go    = frame_end & (y == V_MAX);
  end

  // Pixel assembly, coordinate counters, output strobes and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_wr_en   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      line_err    <= 1'b0;
      r_nib       <= '0;
      x           <= '0;
      y           <= '0;
      line_seen   <= 1'b0;
    end else begin
      pix_wr_en   <= wr_go;
      frame_start <= frame_begin;
      frame_done  <= fd_go;
      if (take_byte1) r_nib <= data_s2[3:0];
      if (wr_go) begin
        pix_data <= {r_nib, data_s2};
        pix_x    <= x;
        pix_y    <= y;
      end
      if (frame_begin) begin
        x <= '0;
        y <= '0;
      end else if (take_byte2) begin
        if (x != 10'h3FF) x <= x + 10'd1;
      end else if (line_end) begin
        x <= '0;
        if (y != 9'h1FF) y <= y + 9'd1;
      end
      if (frame_begin || line_end)      line_seen <= 1'b0;
      else if (take_byte1 || take_byte2) line_seen <= 1'b1;
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (lerr_set)     line_err <= 1'b1;
      else if (err_clr) line_err <= 1'b0;
    end
  end

endmodule

// File: doc/ov7670_pixel_capture.md
Name: ov7670_pixel_capture

Overview:
- Downstream stage of the OV7670 SCCB configuration block. It begins capturing only once configuration is complete.
- Oversamples the camera's parallel bus (pclk, href, vsync, 8-bit data) in the system clock domain.
- Assembles byte pairs into 12-bit RGB444 pixels and pushes them into the downstream pixel FIFO.
- Provides pixel coordinates, frame markers, and sticky error flags for overflow and malformed lines.

Parameters:
- H_PIXELS, 640, active pixels per line (pixel pairs per href-high period)
- V_LINES, 480, active lines per frame

Ports:
- clk  in  1  system clock; must be at least 3x cmos_pclk frequency
- rst_n  in  1  asynchronous active-low reset
- cfg_done  in  1  level; high once SCCB configuration and post-config delay are finished
- cmos_pclk  in  1  camera pixel clock (asynchronous)
- cmos_href  in  1  camera line-valid (asynchronous)
- cmos_vsync  in  1  camera frame sync, high during vertical blank (asynchronous)
- cmos_data  in  8  camera data bus (asynchronous)
- pix_full  in  1  downstream FIFO full
- pix_wr_en  out  1  one-cycle FIFO write strobe
- pix_data  out  12  {R[3:0],G[3:0],B[3:0]}, valid with pix_wr_en
- pix_x  out  10  column of the pixel in pix_data
- pix_y  out  9  line of the pixel in pix_data
- frame_start  out  1  one-cycle pulse on vsync falling edge while capturing
- frame_done  out  1  one-cycle pulse on vsync rising edge after V_LINES complete lines
- overflow  out  1  sticky: a pixel was dropped because pix_full was high
- line_err  out  1  sticky: a line length was not H_PIXELS, a partial pixel occurred, or there were excess lines
- err_clr  in  1  synchronous clear of overflow and line_err

Behaviour:
- Reset: all outputs 0; state WAIT_CFG; counters 0; sync flops 0.
- Synchronisation:
  - pclk, href, vsync and data each pass through 2 flops; pclk and vsync get a third flop for edge detection.
  - pclk rising edge E = pclk_s2 & ~pclk_s3.
  - href and data are sampled as their _s2 values in the cycle E.
- States:
  - WAIT_CFG: stays until cfg_done=1, then goes to WAIT_VS.
  - WAIT_VS: waits for a synced vsync falling edge, then pulses frame_start, sets x=0 and y=0, goes to BYTE1. Any vsync edge before that is ignored, so capture never starts mid-frame.
  - BYTE1: on E with href=1, latch data[3:0] as R and go to BYTE2.
  - BYTE2: on E with href=1:
    - form the pixel {R, data[7:0]} and go to BYTE1;
    - if x<H_PIXELS and y<V_LINES: if !pix_full, pix_wr_en=1 in cycle E+1 with pix_data, pix_x=x, pix_y=y; else drop the pixel and set overflow;
    - if x>=H_PIXELS or y>=V_LINES: drop the pixel and set line_err;
    - x increments, saturating at 1023.
- End of line (on E with href=0 after at least one href=1 sample in this line):
  - if in BYTE2, discard the partial byte, set line_err, return to BYTE1;
  - if x!=H_PIXELS, set line_err;
  - then x=0 and y increments, saturating at 511.
- vsync rising edge while in BYTE1 or BYTE2: frame_done pulses only if y==V_LINES; otherwise set line_err. Then go to WAIT_VS.
- cfg_done falling in any state: go to WAIT_CFG next cycle with no further pix_wr_en. A pending write already scheduled for that cycle completes.
- pix_wr_en, frame_start and frame_done are registered single-cycle pulses. pix_data, pix_x and pix_y hold their value between writes.
- err_clr has priority below a same-cycle set event, so the flag stays 1.
- Asynchronous reset mid-frame aborts immediately. After release, the block needs cfg_done and a fresh vsync falling edge before capturing.

Test Plan:
- Reset release, cfg_done=1, vsync pulse, then 2 lines of 640 pixel pairs (byte1=0x0A, byte2=0x5C) -> frame_start once; 1280 pix_wr_en with pix_data=0xA5C; last write pix_x=639, pix_y=1; no errors.
- Full 640x480 frame followed by vsync rise -> frame_done one pulse; exactly 307200 writes; line_err=0.
- pix_full=1 for pixels 10-12 of line 0 -> those 3 writes absent; overflow=1; pix_x resumes at 13. err_clr -> overflow=0.
- Line with 641 pairs, then a line where href drops after byte1 -> 640 writes from the first line, partial pixel not written, line_err=1.
- cmos_data and href toggling with cfg_done=0, then cfg_done=1 mid-frame -> no writes until the next vsync falling edge; first write pix_x=0, pix_y=0.
- cfg_done dropped mid-line -> writes stop within 1 cycle; state WAIT_CFG; capture restarts only after cfg_done=1 and a new vsync fall.
